limine2600_memarb: RTL and testbench
====================================

Name: limine2600_memarb

Overview:
Two-port memory arbiter and sequencer sitting directly upstream of the Limine2600 128K DRAM. Merges the CPU instruction-fetch port (read-only) and the load/store port onto the single DRAM port. Uses round-robin grant and a fixed-latency read-capture FSM. Rejects writes to the read-only bank (addr[31:16] != 0) and misaligned load/store accesses with a fault flag, without touching memory.

Parameters:
RD_LAT, 1, DRAM read latency in clocks from the edge that samples mem_addr to valid mem_rdata (1..7)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request; held with if_addr stable until if_ack
if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored (forced 0)
if_ack  out  1  one-cycle completion pulse
if_rdata  out  DATA_W  fetched word, valid with if_ack, held until the next if_ack
ls_req  in  1  load/store request; held with ls_we/addr/wdata stable until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  load/store byte address
ls_wdata  in  DATA_W  store data
ls_ack  out  1  one-cycle completion pulse
ls_rdata  out  DATA_W  load data, valid with ls_ack, held until the next ls_ack
ls_fault  out  1  valid with ls_ack: 1 = access rejected
mem_we  out  1  DRAM write enable
mem_addr  out  ADDR_W  DRAM address
mem_wdata  out  DATA_W  DRAM write data
mem_rdata  in  DATA_W  DRAM registered read data
mem_rdy  in  1  DRAM ready; no grant while 0

Behaviour:
- Reset: all outputs 0; state IDLE; cnt 0; last_grant = LS, so IF wins the first conflict. Asserting rst mid-transaction aborts immediately: mem_we drops, no ack is issued, and the requester must retry.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: on an edge with mem_rdy=1 and at least one req:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not equal to last_grant; last_grant updates on grant.
- Fault check (LS only), evaluated at grant: fault = ls_addr[1:0] != 0 OR (ls_we AND ls_addr[31:16] != 0).
  - Faulting grant: go IDLE -> RESP directly. mem_* are untouched; ls_rdata is set to 0 and ls_fault to 1.
- Normal grant: go IDLE -> ACCESS.
  - mem_addr = {addr[31:2], 2'b00}; mem_wdata = ls_wdata for a store.
  - mem_we = 1 only for a store, and only in the first ACCESS cycle.
  - cnt loads RD_LAT.
- ACCESS: lasts RD_LAT+1 cycles; mem_addr is held throughout.
  - On the final ACCESS edge, capture mem_rdata into the granted port's rdata. A store leaves its rdata unchanged.
  - Then go to RESP.
- RESP: the granted port's ack is high for exactly one cycle; ls_fault is valid alongside ls_ack and 0 on non-fault completions. Next state is IDLE, mem_we = 0.
- Latency:
  - Request accepted at edge E0: ack is high in the cycle after edge E0+RD_LAT+2. With RD_LAT=1, that is 3 cycles after acceptance.
  - Fault: ack is high in the cycle after E0+1.
  - Back-to-back throughput: one transaction per RD_LAT+3 cycles. IDLE always costs one cycle, and a req that is still high in the RESP cycle is not double-served.
- A request dropped before ack is a protocol violation and is not checked. A transaction in flight always completes.
- mem_rdy=0 only blocks new grants; it does not stall an in-flight ACCESS.
- Addresses pass through unmodified above bit 1; no wrap handling is required.

Test Plan:
- Reset, mem_rdy=0, if_req=1 for 5 cycles -> no grant, mem_addr=0. Then mem_rdy=1 -> fetch proceeds, if_ack 3 cycles later.
- Preload DRAM word 0x0000_0010 = 0xDEADBEEF; if_req, if_addr=0x0000_0012 -> mem_addr=0x0000_0010; if_ack after 3 cycles with if_rdata=0xDEADBEEF.
- Store ls_addr=0x0000_0020, ls_wdata=0x12345678: mem_we high exactly 1 cycle, ls_ack with ls_fault=0. Then load 0x0000_0020 -> ls_rdata=0x12345678.
- Store to 0x0001_0000 -> ls_ack 1 cycle after grant, ls_fault=1, ls_rdata=0, mem_we never high. Load from 0x0000_0003 -> same fault behaviour.
- Both reqs held continuously from reset -> grants alternate IF, LS, IF, LS; acks are never simultaneous; spacing is 4 cycles.
- Assert rst during ACCESS of a store -> mem_we=0 and all acks 0 at once. After release, last_grant = LS, so a simultaneous request grants IF first.

Source files
------------

// File: rtl/limine2600_memarb.sv
// Limine2600 DRAM front end: round-robin arbiter between the fetch and load/store ports,
// with a fixed-latency read-capture sequencer and fault rejection of bad load/store accesses.
module limine2600_memarb #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_fault,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy
);

    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              gnt_ls_q, gnt_ls_d;
    logic              last_ls_q, last_ls_d;
    logic              store_q, store_d;
    logic              fault_q, fault_d;
    logic              if_ack_q, if_ack_d;
    logic              ls_ack_q, ls_ack_d;
    logic              ls_fault_q, ls_fault_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic              if_ok;
    logic              ls_ok;
    logic              pick_ls;
    logic              ls_bad;
    logic [ADDR_W-1:0] sel_addr;

    // A port whose ack is still showing is skipped, so a req held into that cycle is not
    // served twice.
    assign if_ok    = if_req & ~if_ack_q;
    assign ls_ok    = ls_req & ~ls_ack_q;
    assign pick_ls  = ls_ok & (~if_ok | ~last_ls_q);
    assign ls_bad   = (ls_addr[1:0] != 2'b00) | (ls_we & (ls_addr[ADDR_W-1:16] != '0));
    assign sel_addr = pick_ls ? ls_addr : if_addr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_ls_d    = gnt_ls_q;
        last_ls_d   = last_ls_q;
        store_d     = store_q;
        fault_d     = fault_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        ls_fault_d  = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (mem_rdy && (if_ok || ls_ok)) begin
                    gnt_ls_d  = pick_ls;
                    last_ls_d = pick_ls;
                    if (pick_ls && ls_bad) begin
                        // Rejected access: skip the DRAM entirely.
                        state_d    = StResp;
                        fault_d    = 1'b1;
                        store_d    = 1'b0;
                        ls_rdata_d = '0;
                    end else begin
                        state_d    = StAccess;
                        fault_d    = 1'b0;
                        cnt_d      = CntW'(RD_LAT);
                        mem_addr_d = {sel_addr[ADDR_W-1:2], 2'b00};
                        store_d    = pick_ls & ls_we;
                        if (pick_ls && ls_we) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = ls_wdata;
                        end
                    end
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    if (!gnt_ls_q) begin
                        if_rdata_d = mem_rdata;
                    end else if (!store_q) begin
                        ls_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
                if (gnt_ls_q) begin
                    ls_ack_d   = 1'b1;
                    ls_fault_d = fault_q;
                end else begin
                    if_ack_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            gnt_ls_q    <= 1'b0;
            last_ls_q   <= 1'b1;
            store_q     <= 1'b0;
            fault_q     <= 1'b0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            ls_fault_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_ls_q    <= gnt_ls_d;
            last_ls_q   <= last_ls_d;
            store_q     <= store_d;
            fault_q     <= fault_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            ls_fault_q  <= ls_fault_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign ls_ack    = ls_ack_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_fault  = ls_fault_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_limine2600_memarb.sv
// Self-checking bench for limine2600_memarb: directed scenarios plus random single and
// simultaneous transactions against a transaction-level memory/arbitration model.
module tb_limine2600_memarb;

    localparam int unsigned RD_LAT    = 1;
    localparam int          LAT_OK    = RD_LAT + 3;  // negedges from raising req to seeing ack
    localparam int          LAT_FAULT = 2;

    logic        clk, rst;
    logic        if_req, if_ack, ls_req, ls_we, ls_ack, ls_fault, mem_we, mem_rdy;
    logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // DRAM model: 1024 aliased words, registered read of one cycle.
    bit [31:0] dram [1024];
    bit        dram_v [1024];
    bit [31:0] ref_mem [1024];
    bit        ref_v [1024];

    int          vec_cnt, err_cnt, we_cycles;
    bit          model_last_ls;
    logic [31:0] exp_ls_rdata;

    limine2600_memarb #(.RD_LAT(RD_LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_ack   (ls_ack),
        .ls_rdata (ls_rdata),
        .ls_fault (ls_fault),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy  (mem_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [9:0] k);
        if (k == 10'd4) return 32'hDEAD_BEEF;
        return {20'h0, k, 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= dram_v[mem_addr[11:2]] ? dram[mem_addr[11:2]] : init_word(mem_addr[11:2]);
        if (mem_we) begin
            dram[mem_addr[11:2]]   <= mem_wdata;
            dram_v[mem_addr[11:2]] <= 1'b1;
        end
    end

    always @(posedge clk) if (mem_we) we_cycles++;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_v[a[11:2]] ? ref_mem[a[11:2]] : init_word(a[11:2]);
    endfunction

    function automatic bit is_fault(input bit we, input logic [31:0] a);
        return (a[1:0] != 2'b00) || (we && a[31:16] != 16'h0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_last_ls = 1'b1;
        exp_ls_rdata  = '0;
    endtask

    task automatic do_txn(input bit is_ls, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bit flt, seen;
        int lat, we0;
        flt  = is_ls && is_fault(we, addr);
        we0  = we_cycles;
        seen = 1'b0;
        lat  = 0;
        mem_rdy = 1'b1;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (c == 1 && !flt) begin
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_we_first", 32'(mem_we), 32'(is_ls && we));
                if (is_ls && we) check("mem_wdata", mem_wdata, wdata);
            end
            if (is_ls ? ls_ack : if_ack) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check("ack_latency", 32'(lat), 32'(flt ? LAT_FAULT : LAT_OK));
        check("other_ack", 32'(is_ls ? if_ack : ls_ack), 32'd0);
        model_last_ls = is_ls;
        if (!is_ls) begin
            check("if_rdata", if_rdata, ref_read(addr));
        end else begin
            if (flt) exp_ls_rdata = '0;
            else if (!we) exp_ls_rdata = ref_read(addr);
            check("ls_rdata", ls_rdata, exp_ls_rdata);
            check("ls_fault", 32'(ls_fault), 32'(flt));
            if (we && !flt) begin
                ref_mem[addr[11:2]] = wdata;
                ref_v[addr[11:2]]   = 1'b1;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
        check("ack_pulse", 32'(if_ack | ls_ack), 32'd0);
        check("mem_we_cycles", 32'(we_cycles - we0), 32'(is_ls && we && !flt));
    endtask

    task automatic do_pair(input logic [31:0] ia, input bit we, input logic [31:0] la,
                           input logic [31:0] wdata);
        bit flt, first_ls;
        int lat_ls, t_if, t_ls;
        flt      = is_fault(we, la);
        lat_ls   = flt ? LAT_FAULT : LAT_OK;
        first_ls = !model_last_ls;
        model_last_ls = !first_ls;
        mem_rdy = 1'b1;
        if_req = 1'b1; if_addr = ia;
        ls_req = 1'b1; ls_we = we; ls_addr = la; ls_wdata = wdata;
        t_if = 0;
        t_ls = 0;
        for (int c = 1; c <= 40 && (t_if == 0 || t_ls == 0); c++) begin
            @(negedge clk);
            check("ack_overlap", 32'(if_ack & ls_ack), 32'd0);
            if (if_ack && t_if == 0) begin
                t_if = c;
                if_req = 1'b0;
                check("pair_if_rdata", if_rdata, ref_read(ia));
            end
            if (ls_ack && t_ls == 0) begin
                t_ls = c;
                ls_req = 1'b0;
                if (flt) exp_ls_rdata = '0;
                else if (!we) exp_ls_rdata = ref_read(la);
                check("pair_ls_rdata", ls_rdata, exp_ls_rdata);
                check("pair_ls_fault", 32'(ls_fault), 32'(flt));
                if (we && !flt) begin
                    ref_mem[la[11:2]] = wdata;
                    ref_v[la[11:2]]   = 1'b1;
                end
            end
        end
        check("pair_t_if", 32'(t_if), 32'(first_ls ? lat_ls + LAT_OK : LAT_OK));
        check("pair_t_ls", 32'(t_ls), 32'(first_ls ? lat_ls : LAT_OK + lat_ls));
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(64, 95)) << 2;
        if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom_range(1, 65535));
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        int   ack_t[$];
        bit   ack_ls[$];
        logic [31:0] ia, la, wd;
        bit   w;

        vec_cnt = 0; err_cnt = 0; we_cycles = 0;
        if_req = 0; ls_req = 0; ls_we = 0; mem_rdy = 1;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last_ls = 1'b1;
        exp_ls_rdata  = '0;
        @(negedge clk);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_ls_ack", 32'(ls_ack), 32'd0);
        check("rst_ls_fault", 32'(ls_fault), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);

        // No grant while DRAM is not ready.
        mem_rdy = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0012;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("nordy_mem_addr", mem_addr, 32'd0);
            check("nordy_if_ack", 32'(if_ack), 32'd0);
        end
        do_txn(1'b0, 1'b0, 32'h0000_0012, '0);
        do_txn(1'b0, 1'b0, 32'h0000_0010, '0);

        do_txn(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
        do_txn(1'b1, 1'b0, 32'h0000_0020, '0);
        check("load_after_store", ls_rdata, 32'h1234_5678);
        do_txn(1'b1, 1'b1, 32'h0001_0000, 32'hFFFF_0000);
        do_txn(1'b1, 1'b0, 32'h0000_0003, '0);
        do_txn(1'b1, 1'b1, 32'h0000_0024, 32'h0BAD_F00D);
        do_txn(1'b1, 1'b0, 32'h0001_0024, '0);

        // Both requests held from reset: strict alternation starting with IF.
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0044;
        mem_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 8 * LAT_OK + 2; c++) begin
            @(negedge clk);
            check("hold_overlap", 32'(if_ack & ls_ack), 32'd0);
            if (if_ack) begin
                ack_t.push_back(c); ack_ls.push_back(1'b0);
                check("hold_if_rdata", if_rdata, ref_read(32'h40));
            end
            if (ls_ack) begin
                ack_t.push_back(c); ack_ls.push_back(1'b1);
                check("hold_ls_rdata", ls_rdata, ref_read(32'h44));
            end
        end
        check("hold_ack_count", 32'(ack_t.size()), 32'd8);
        for (int i = 0; i < ack_t.size(); i++) begin
            check("hold_port", 32'(ack_ls[i]), 32'(i % 2));
            check("hold_time", 32'(ack_t[i]), 32'(LAT_OK * (i + 1)));
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (2 * LAT_OK) @(negedge clk);

        // Reset during the ACCESS of a store aborts it; afterwards IF wins the first conflict.
        do_reset();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0080; ls_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("abort_pre_mem_we", 32'(mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_acks", 32'(if_ack | ls_ack), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        ls_req = 1'b0;
        rst = 1'b0;
        model_last_ls = 1'b1;
        exp_ls_rdata  = '0;
        @(negedge clk);
        do_pair(32'h0000_0084, 1'b0, 32'h0000_0088, '0);

        for (int n = 0; n < 150; n++) begin
            ia = rnd_addr();
            la = rnd_addr();
            wd = $urandom;
            w  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) do_pair(ia, w, la, wd);
            else if ($urandom_range(0, 2) == 0) do_txn(1'b0, 1'b0, ia, '0);
            else do_txn(1'b1, w, la, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vec_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
